// File: rtl/vtg_pkg.sv
// Shared timing defaults, counter type and window helpers for the video timing generator.
package vtg_pkg;

    localparam int unsigned VTG_CNT_W = 9;

    typedef logic [VTG_CNT_W-1:0] vtg_cnt_t;

    localparam int unsigned VTG_MCLK_DIV   = 6;
    localparam int unsigned VTG_H_START    = 128;
    localparam int unsigned VTG_H_END      = 511;
    localparam int unsigned VTG_V_START    = 248;
    localparam int unsigned VTG_V_END      = 511;
    localparam int unsigned VTG_VINC_HPOS  = 175;
    localparam int unsigned VTG_HACT_START = 256;
    localparam int unsigned VTG_VACT_START = 272;
    localparam int unsigned VTG_VACT_END   = 495;
    localparam int unsigned VTG_HS_START   = 175;
    localparam int unsigned VTG_HS_END     = 206;
    localparam int unsigned VTG_VS_START   = 248;
    localparam int unsigned VTG_VS_END     = 255;
    localparam int unsigned VTG_DMA_START  = 480;
    localparam int unsigned VTG_DMA_END    = 495;
    localparam int unsigned VTG_BLK_DLY    = 22;
    localparam int unsigned VTG_OBJ_DLY    = 18;

    // Inclusive window test on a live counter value.
    function automatic logic vtg_in_win(input vtg_cnt_t cnt, input vtg_cnt_t lo,
                                        input vtg_cnt_t hi);
        return (cnt >= lo) && (cnt <= hi);
    endfunction

    // Elaboration helper: window [lo,hi] is ordered and lies inside [rlo,rhi].
    function automatic bit vtg_win_ok(input int unsigned lo, input int unsigned hi,
                                      input int unsigned rlo, input int unsigned rhi);
        return (lo <= hi) && (lo >= rlo) && (hi <= rhi);
    endfunction

endpackage

// File: rtl/vtg_cen_gen.sv
// Master-clock divider producing the registered, active-low pixel clock-enable pair.
module vtg_cen_gen
    import vtg_pkg::*;
#(
    parameter int unsigned MCLK_DIV = VTG_MCLK_DIV
) (
    input  logic i_EMU_MCLK,
    input  logic i_MRST,
    output logic o_PXCEN_n,
    output logic o_PXNEGCEN_n
);

    localparam int unsigned DIV_W = (MCLK_DIV < 2) ? 1 : $clog2(MCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(MCLK_DIV / 2 - 1);

    if (MCLK_DIV < 2 || (MCLK_DIV % 2) != 0) begin : g_bad_div
        $error("vtg_cen_gen: MCLK_DIV must be even and at least 2");
    end

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_d;
    logic             r_pxcen_n;
    logic             r_pxnegcen_n;

    assign w_div_d = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);

    // Enables are decoded from the next divider value so they are low exactly while the
    // divider holds that value, yet still come straight from a flop.
    always_ff @(posedge i_EMU_MCLK) begin
        if (i_MRST) begin
            r_div        <= '0;
            r_pxcen_n    <= 1'b1;
            r_pxnegcen_n <= 1'b1;
        end else begin
            r_div        <= w_div_d;
            r_pxcen_n    <= (w_div_d != DIV_LAST);
            r_pxnegcen_n <= (w_div_d != DIV_HALF);
        end
    end

    assign o_PXCEN_n    = r_pxcen_n;
    assign o_PXNEGCEN_n = r_pxnegcen_n;

endmodule

// File: rtl/param_video_timing_generator.sv
// Parameterised raster timing: H/V counters, sync/blank/DMA decode and delayed blank taps.
// Optional raster-line interrupt is built only when VTG_LINEIRQ_EN is defined.
module param_video_timing_generator
    import vtg_pkg::*;
#(
    parameter int unsigned MCLK_DIV   = VTG_MCLK_DIV,
    parameter int unsigned H_START    = VTG_H_START,
    parameter int unsigned H_END      = VTG_H_END,
    parameter int unsigned V_START    = VTG_V_START,
    parameter int unsigned V_END      = VTG_V_END,
    parameter int unsigned VINC_HPOS  = VTG_VINC_HPOS,
    parameter int unsigned HACT_START = VTG_HACT_START,
    parameter int unsigned VACT_START = VTG_VACT_START,
    parameter int unsigned VACT_END   = VTG_VACT_END,
    parameter int unsigned HS_START   = VTG_HS_START,
    parameter int unsigned HS_END     = VTG_HS_END,
    parameter int unsigned VS_START   = VTG_VS_START,
    parameter int unsigned VS_END     = VTG_VS_END,
    parameter int unsigned DMA_START  = VTG_DMA_START,
    parameter int unsigned DMA_END    = VTG_DMA_END,
    parameter int unsigned BLK_DLY    = VTG_BLK_DLY,
    parameter int unsigned OBJ_DLY    = VTG_OBJ_DLY
) (
    input  logic                 i_EMU_MCLK,
    input  logic                 i_MRST,
    input  logic                 i_HFLIP,
    input  logic                 i_VFLIP,
    input  logic [VTG_CNT_W-1:0] i_IRQLINE,
    input  logic                 i_IRQACK,
    output logic                 o_PXCEN_n,
    output logic                 o_PXNEGCEN_n,
    output logic [VTG_CNT_W-1:0] o_HCNTR,
    output logic [VTG_CNT_W-1:0] o_VCNTR,
    output logic [7:0]           o_HFLIPCNTR,
    output logic [7:0]           o_VFLIPCNTR,
    output logic                 o_HBLANK_n,
    output logic                 o_VBLANK_n,
    output logic                 o_HSYNC_n,
    output logic                 o_VSYNC_n,
    output logic                 o_CSYNC_n,
    output logic                 o_FRAMEPARITY,
    output logic                 o_DMA_n,
    output logic                 o_BLANK_n,
    output logic                 o_OBJBUFCLR,
    output logic                 o_IRQ_n
);

    localparam int unsigned CNT_MAX = (1 << VTG_CNT_W) - 1;

    localparam bit H_OK    = vtg_win_ok(H_START, H_END, 0, CNT_MAX);
    localparam bit V_OK    = vtg_win_ok(V_START, V_END, 0, CNT_MAX);
    localparam bit VINC_OK = vtg_win_ok(VINC_HPOS, VINC_HPOS, H_START, H_END);
    localparam bit HACT_OK = vtg_win_ok(HACT_START, HACT_START, H_START, H_END);
    localparam bit VACT_OK = vtg_win_ok(VACT_START, VACT_END, V_START, V_END);
    localparam bit HS_OK   = vtg_win_ok(HS_START, HS_END, H_START, H_END);
    localparam bit VS_OK   = vtg_win_ok(VS_START, VS_END, V_START, V_END);
    localparam bit DMA_OK  = vtg_win_ok(DMA_START, DMA_END, V_START, V_END);
    localparam bit DLY_OK  = (OBJ_DLY >= 1) && (OBJ_DLY <= BLK_DLY);

    if (!H_OK || !V_OK) begin : g_bad_range
        $error("param_video_timing_generator: H/V count range reversed or too wide");
    end
    if (!VINC_OK || !HACT_OK || !HS_OK) begin : g_bad_hwin
        $error("param_video_timing_generator: horizontal window outside H range");
    end
    if (!VACT_OK || !VS_OK || !DMA_OK) begin : g_bad_vwin
        $error("param_video_timing_generator: vertical window outside V range");
    end
    if (!DLY_OK) begin : g_bad_dly
        $error("param_video_timing_generator: need 1 <= OBJ_DLY <= BLK_DLY");
    end

    localparam vtg_cnt_t C_H_START    = vtg_cnt_t'(H_START);
    localparam vtg_cnt_t C_H_END      = vtg_cnt_t'(H_END);
    localparam vtg_cnt_t C_V_START    = vtg_cnt_t'(V_START);
    localparam vtg_cnt_t C_V_END      = vtg_cnt_t'(V_END);
    localparam vtg_cnt_t C_VINC_HPOS  = vtg_cnt_t'(VINC_HPOS);
    localparam vtg_cnt_t C_HACT_START = vtg_cnt_t'(HACT_START);
    localparam vtg_cnt_t C_VACT_START = vtg_cnt_t'(VACT_START);
    localparam vtg_cnt_t C_VACT_END   = vtg_cnt_t'(VACT_END);
    localparam vtg_cnt_t C_HS_START   = vtg_cnt_t'(HS_START);
    localparam vtg_cnt_t C_HS_END     = vtg_cnt_t'(HS_END);
    localparam vtg_cnt_t C_VS_START   = vtg_cnt_t'(VS_START);
    localparam vtg_cnt_t C_VS_END     = vtg_cnt_t'(VS_END);
    localparam vtg_cnt_t C_DMA_START  = vtg_cnt_t'(DMA_START);
    localparam vtg_cnt_t C_DMA_END    = vtg_cnt_t'(DMA_END);

    logic w_pxcen_n;
    logic w_pxnegcen_n;
    logic w_pxcen;

    vtg_cen_gen #(
        .MCLK_DIV (MCLK_DIV)
    ) u_cen_gen (
        .i_EMU_MCLK   (i_EMU_MCLK),
        .i_MRST       (i_MRST),
        .o_PXCEN_n    (w_pxcen_n),
        .o_PXNEGCEN_n (w_pxnegcen_n)
    );

    assign w_pxcen = ~w_pxcen_n;

    vtg_cnt_t           r_hcnt;
    vtg_cnt_t           r_vcnt;
    logic               r_parity;
    logic [BLK_DLY-1:0] r_blk_sr;

    vtg_cnt_t           w_hcnt_d;
    vtg_cnt_t           w_vcnt_d;
    logic               w_vinc;
    logic               w_vwrap;
    logic               w_hblank_n;
    logic               w_vblank_n;
    logic               w_hsync_n;
    logic               w_vsync_n;
    logic               w_blank_src;
    logic [BLK_DLY:0]   w_blk_sr_shift;

    assign w_vinc   = (r_hcnt == C_VINC_HPOS);
    assign w_vwrap  = w_vinc && (r_vcnt == C_V_END);
    assign w_hcnt_d = (r_hcnt == C_H_END) ? C_H_START : r_hcnt + vtg_cnt_t'(1);

    always_comb begin
        w_vcnt_d = r_vcnt;
        if (w_vinc) begin
            w_vcnt_d = (r_vcnt == C_V_END) ? C_V_START : r_vcnt + vtg_cnt_t'(1);
        end
    end

    assign w_hblank_n     = (r_hcnt >= C_HACT_START);
    assign w_vblank_n     = vtg_in_win(r_vcnt, C_VACT_START, C_VACT_END);
    assign w_hsync_n      = ~vtg_in_win(r_hcnt, C_HS_START, C_HS_END);
    assign w_vsync_n      = ~vtg_in_win(r_vcnt, C_VS_START, C_VS_END);
    assign w_blank_src    = w_hblank_n & w_vblank_n;
    // Stage 0 is the newest sample; stage N-1 is the blank seen N pixels ago.
    assign w_blk_sr_shift = {r_blk_sr, w_blank_src};

    always_ff @(posedge i_EMU_MCLK) begin
        if (i_MRST) begin
            r_hcnt   <= C_H_END;
            r_vcnt   <= C_V_END;
            r_parity <= 1'b0;
            r_blk_sr <= '1;
        end else if (w_pxcen) begin
            r_hcnt   <= w_hcnt_d;
            r_vcnt   <= w_vcnt_d;
            r_parity <= r_parity ^ w_vwrap;
            r_blk_sr <= w_blk_sr_shift[BLK_DLY-1:0];
        end
    end

`ifdef VTG_LINEIRQ_EN
    logic r_irq_n;
    logic w_irq_match;

    // Only fires on the pixel where V actually steps onto the compare line; an in-range
    // guard keeps out-of-raster lines from ever matching.
    assign w_irq_match = w_pxcen && w_vinc && (w_vcnt_d == i_IRQLINE) &&
                         vtg_in_win(i_IRQLINE, C_V_START, C_V_END);

    always_ff @(posedge i_EMU_MCLK) begin
        if (i_MRST) begin
            r_irq_n <= 1'b1;
        end else if (w_irq_match) begin
            r_irq_n <= 1'b0;
        end else if (i_IRQACK) begin
            r_irq_n <= 1'b1;
        end
    end

    assign o_IRQ_n = r_irq_n;
`else
    logic w_unused_irq;

    assign w_unused_irq = ^{i_IRQLINE, i_IRQACK};
    assign o_IRQ_n      = 1'b1;
`endif

    assign o_PXCEN_n     = w_pxcen_n;
    assign o_PXNEGCEN_n  = w_pxnegcen_n;
    assign o_HCNTR       = r_hcnt;
    assign o_VCNTR       = r_vcnt;
    assign o_HFLIPCNTR   = r_hcnt[7:0] ^ {8{i_HFLIP}};
    assign o_VFLIPCNTR   = r_vcnt[7:0] ^ {8{i_VFLIP}};
    assign o_HBLANK_n    = w_hblank_n;
    assign o_VBLANK_n    = w_vblank_n;
    assign o_HSYNC_n     = w_hsync_n;
    assign o_VSYNC_n     = w_vsync_n;
    assign o_CSYNC_n     = w_hsync_n & w_vsync_n;
    assign o_FRAMEPARITY = r_parity;
    assign o_DMA_n       = ~vtg_in_win(r_vcnt, C_DMA_START, C_DMA_END);
    assign o_BLANK_n     = r_blk_sr[BLK_DLY-1];
    assign o_OBJBUFCLR   = r_blk_sr[OBJ_DLY-1];

endmodule

// File: doc/param_video_timing_generator.md
PARAM_VIDEO_TIMING_GENERATOR -- requirements
Module: param_video_timing_generator

Interface
REQ-001 SHALL accept parameter MCLK_DIV, default 6, master-clock cycles per pixel; even, >=2.
REQ-002 SHALL accept parameters H_START 128 / H_END 511, horizontal count range, inclusive.
REQ-003 SHALL accept parameters V_START 248 / V_END 511, vertical count range, inclusive.
REQ-004 SHALL accept parameter VINC_HPOS, default 175, H value at which V advances.
REQ-005 SHALL accept parameters HACT_START 256, VACT_START 272, VACT_END 495, active-video window.
REQ-006 SHALL accept parameters HS_START 175 / HS_END 206 and VS_START 248 / VS_END 255, sync windows.
REQ-007 SHALL accept parameters DMA_START 480 / DMA_END 495, DMA line window.
REQ-008 SHALL accept parameters BLK_DLY 22 / OBJ_DLY 18, blank delay taps in pixels; 1 <= OBJ_DLY <= BLK_DLY.
REQ-009 Ports: i_EMU_MCLK in 1 master clock; i_MRST in 1 reset; i_HFLIP in 1; i_VFLIP in 1; i_IRQLINE in 9 raster-compare line; i_IRQACK in 1.
REQ-010 Ports: o_PXCEN_n out 1; o_PXNEGCEN_n out 1; o_HCNTR out 9; o_VCNTR out 9; o_HFLIPCNTR out 8; o_VFLIPCNTR out 8.
REQ-011 Ports: o_HBLANK_n, o_VBLANK_n, o_HSYNC_n, o_VSYNC_n, o_CSYNC_n, o_FRAMEPARITY, o_DMA_n, o_BLANK_n, o_OBJBUFCLR, o_IRQ_n, all out 1.
REQ-012 The block SHALL have one clock, i_EMU_MCLK; reset i_MRST SHALL be synchronous and active-high.

Function
REQ-013 Divider counts 0..MCLK_DIV-1 on every i_EMU_MCLK rising edge and wraps to 0.
REQ-014 o_PXCEN_n SHALL be low for exactly one MCLK when the divider is MCLK_DIV-1; o_PXNEGCEN_n SHALL be low for one MCLK when it is MCLK_DIV/2-1.
REQ-015 On a PXCEN cycle, H increments; at H_END it wraps to H_START.
REQ-016 On a PXCEN cycle with H==VINC_HPOS, V increments; at V_END it wraps to V_START and o_FRAMEPARITY toggles.
REQ-017 o_HFLIPCNTR = H[7:0] XOR {8{i_HFLIP}}; o_VFLIPCNTR = V[7:0] XOR {8{i_VFLIP}}; both combinational.
REQ-018 The following SHALL be combinational from the counters: o_HBLANK_n = (H >= HACT_START); o_VBLANK_n = (VACT_START <= V <= VACT_END).
REQ-019 o_HSYNC_n and o_VSYNC_n SHALL be low inside their inclusive windows; o_CSYNC_n = o_HSYNC_n AND o_VSYNC_n.
REQ-020 o_DMA_n SHALL be low while DMA_START <= V <= DMA_END.
REQ-021 A BLK_DLY-stage shift register SHALL shift (o_HBLANK_n AND o_VBLANK_n) on PXCEN cycles only.
REQ-022 o_BLANK_n SHALL be stage BLK_DLY-1 of that shift register; o_OBJBUFCLR SHALL be stage OBJ_DLY-1.
REQ-023 IRQ: on the PXCEN cycle where V takes the value i_IRQLINE, o_IRQ_n SHALL fall; it SHALL stay low until a cycle with i_IRQACK=1.
REQ-024 Ack and a new match in the same cycle: match wins, o_IRQ_n stays low; ack while high has no effect.
REQ-025 i_IRQLINE outside V_START..V_END SHALL never fire.
REQ-026 Illegal parameter combinations (ranges reversed, MCLK_DIV odd or <2, windows outside count range) SHALL fail elaboration.

Reset
REQ-027 i_MRST=1 SHALL override PXCEN and set: divider 0, H=H_END, V=V_END, o_FRAMEPARITY 0, shift register all 1, o_IRQ_n 1, both CEN outputs 1.
REQ-028 After release, the first PXCEN SHALL move H to H_START; reset mid-frame SHALL restart the frame identically.

Configuration
REQ-029 Macro VTG_LINEIRQ_EN defined: REQ-023..025 are implemented.
REQ-030 Macro VTG_LINEIRQ_EN undefined: o_IRQ_n is constant 1; i_IRQLINE and i_IRQACK are ignored; no IRQ logic is present.

Structure
REQ-031 Package vtg_pkg SHALL hold the default timing constants (all REQ-001..008 defaults) and counter width constant 9.
REQ-032 Sub-module vtg_cen_gen SHALL implement the divider and CEN pair (REQ-013/014), parameterised by MCLK_DIV.

Verification
REQ-033 Defaults, release reset -> o_PXCEN_n low at MCLK 6, 12, 18...; o_PXNEGCEN_n low at MCLK 3, 9, 15...
REQ-034 Run past H=511 -> next H=128; o_HSYNC_n low for exactly 32 pixels (H 175..206); 384 pixels per line.
REQ-035 Run two frames -> 101376 PXCEN per frame; FRAMEPARITY toggles once per frame; VSYNC_n low on lines 248..255; DMA_n low on lines 480..495.
REQ-036 Compare delays -> o_BLANK_n equals the AND-ed blank delayed 22 PXCEN; o_OBJBUFCLR equals it delayed 18 PXCEN.
REQ-037 i_IRQLINE=300 -> o_IRQ_n falls when V becomes 300; ack held across the next match -> stays low; macro undefined -> o_IRQ_n always 1.
REQ-038 i_HFLIP=1 at H=0x080 -> o_HFLIPCNTR=0x7F; i_MRST pulse mid-line -> H=511, V=511 next cycle, then H=128.
